// File: rtl/sao_stat_pkg.sv
// SAO CTB statistics: shared state type, default widths
// and saturating adders used by the per-category cells.
package sao_stat_pkg;

  localparam int SAO_SUM_W = 18;
  localparam int SAO_CNT_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } sao_acc_state_t;

  // Signed add clamped to a w-bit two's complement range.
  function automatic longint sat_add_s(
    input longint a,
    input longint b,
    input int     w
  );
    longint s;
    longint hi;
    longint lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

  function automatic longint sat_add_u(
    input longint a,
    input longint b,
    input int     w
  );
    longint s;
    longint hi;
    s  = a + b;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (s > hi) s = hi;
    return s;
  endfunction

endpackage

// File: rtl/sao_stat_acc_cell.sv
// One category's saturating diff-sum and pixel-count
// accumulators with synchronous clear and beat enable.
module sao_stat_acc_cell
  import sao_stat_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int SUM_W = SAO_SUM_W,
  parameter int CNT_W = SAO_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [IN_W-1:0]         add_s_i,
  input  logic [2:0]              add_c_i,
  output logic signed [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0]        cnt_o
);

  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] sum_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  longint                  s_nx;
  longint                  c_nx;

  always_comb begin
    s_nx  = sat_add_s(longint'(sum_q),
                      longint'($signed(add_s_i)), SUM_W);
    c_nx  = sat_add_u(longint'(cnt_q),
                      longint'(add_c_i), CNT_W);
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      sum_d = SUM_W'(s_nx);
      cnt_d = CNT_W'(c_nx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_o = sum_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/sao_stat_ctb_accum.sv
// Per-CTB SAO statistics: accumulate per-category (sum, count)
// over the CTB, then stream the pairs out over valid/ready.
module sao_stat_ctb_accum
  import sao_stat_pkg::*;
#(
  parameter int N_CATE        = 32,
  parameter int diff_clip_bit = 4,
  parameter int SUM_W         = SAO_SUM_W,
  parameter int CNT_W         = SAO_CNT_W,
  localparam int IN_W         = diff_clip_bit + 4,
  localparam int IDX_W        = $clog2(N_CATE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic [N_CATE-1:0][IN_W-1:0]      s51_in,
  input  logic [N_CATE-1:0][2:0]           cnt_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_W-1:0]                 out_idx,
  output logic signed [SUM_W-1:0]          out_sum,
  output logic [CNT_W-1:0]                 out_cnt,
  output logic                             busy,
  output logic                             done
);

  sao_acc_state_t   state_q;
  sao_acc_state_t   state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             done_q;
  logic             done_d;
  logic             clr;
  logic             en;

  logic signed [SUM_W-1:0] sum_w [N_CATE];
  logic [CNT_W-1:0]        cnt_w [N_CATE];

  for (genvar g = 0; g < N_CATE; g++) begin : g_cell
    sao_stat_acc_cell #(
      .IN_W  (IN_W),
      .SUM_W (SUM_W),
      .CNT_W (CNT_W)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .en_i    (en),
      .add_s_i (s51_in[g]),
      .add_c_i (cnt_in[g]),
      .sum_o   (sum_w[g]),
      .cnt_o   (cnt_w[g])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        en = in_valid;
        if (in_valid && in_last) begin
          state_d = OUT;
          idx_d   = '0;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(N_CATE - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_idx   = idx_q;
  assign out_sum   = out_valid ? sum_w[idx_q] : '0;
  assign out_cnt   = out_valid ? cnt_w[idx_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sao_stat_ctb_accum.sv
// Bench: default-width DUT and a narrow-width DUT share stimulus;
// both are checked against plain clamped-arithmetic totals.
module tb_sao_stat_ctb_accum;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0][7:0] s51_in = '0;
  logic [N-1:0][2:0] cnt_in = '0;

  logic              ov_a, busy_a, done_a;
  logic [4:0]        idx_a;
  logic signed [17:0] sum_a;
  logic [12:0]       cnt_a;
  logic              ov_b, busy_b, done_b;
  logic [4:0]        idx_b;
  logic signed [7:0] sum_b;
  logic [5:0]        cnt_b;

  sao_stat_ctb_accum u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_last(in_last),
    .s51_in(s51_in), .cnt_in(cnt_in),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_idx(idx_a), .out_sum(sum_a), .out_cnt(cnt_a),
    .busy(busy_a), .done(done_a)
  );

  sao_stat_ctb_accum #(.SUM_W(8), .CNT_W(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_last(in_last),
    .s51_in(s51_in), .cnt_in(cnt_in),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_idx(idx_b), .out_sum(sum_b), .out_cnt(cnt_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  longint ms_a[N], mc_a[N], ms_b[N], mc_b[N];

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint clampv(longint v, longint lo, longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      ms_a[k] = 0; mc_a[k] = 0; ms_b[k] = 0; mc_b[k] = 0;
    end
  endtask

  task automatic model_beat();
    longint v, c;
    for (int k = 0; k < N; k++) begin
      v = longint'($signed(s51_in[k]));
      c = longint'(cnt_in[k]);
      ms_a[k] = clampv(ms_a[k] + v, -131072, 131071);
      mc_a[k] = clampv(mc_a[k] + c, 0, 8191);
      ms_b[k] = clampv(ms_b[k] + v, -128, 127);
      mc_b[k] = clampv(mc_b[k] + c, 0, 63);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_busy8"}, busy_b, 0);
    chk({tag, "_ov"}, ov_a, 0);
    chk({tag, "_sum0"}, sum_a, 0);
    chk({tag, "_idx"}, idx_a, 0);
  endtask

  task automatic begin_ctb();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("start_busy", busy_a, 1);
    chk("start_busy8", busy_b, 1);
  endtask

  task automatic beat(input bit last);
    in_valid = 1'b1;
    in_last = last;
    tick();
    model_beat();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic rand_vec();
    for (int k = 0; k < N; k++) begin
      s51_in[k] = 8'($urandom);
      cnt_in[k] = 3'($urandom_range(0, 5));
    end
  endtask

  // mode 0: always ready; 1: stall at stall_idx; 2: random ready
  task automatic readout(input int mode, input int stall_idx,
                         input int stall_len);
    int k = 0;
    int cyc = 0;
    int st = 0;
    bit rdy;
    while (k < N && cyc < 2000) begin
      @(negedge clk);
      chk("ov", ov_a, 1);
      chk("ov8", ov_b, 1);
      chk("idx", idx_a, k);
      chk("idx8", idx_b, k);
      chk("sum", sum_a, ms_a[k]);
      chk("cnt", cnt_a, mc_a[k]);
      chk("sum8", sum_b, ms_b[k]);
      chk("cnt8", cnt_b, mc_b[k]);
      chk("nodone", done_a, 0);
      rdy = 1'b1;
      if (mode == 1 && k == stall_idx && st < stall_len) begin
        rdy = 1'b0;
        st++;
      end else if (mode == 2) begin
        rdy = 1'($urandom);
      end
      out_ready = rdy;
      tick();
      if (rdy) k++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("readout_bound", k, N);
    chk("done", done_a, 1);
    chk("done8", done_b, 1);
    chk("end_busy", busy_a, 0);
    chk("end_ov", ov_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    model_clear();
    tick();
    tick();
    chk_idle("rst");
    chk("rst_done", done_a, 0);
    rst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    // single active category
    begin_ctb();
    s51_in = '0; cnt_in = '0;
    s51_in[3] = 8'd7; cnt_in[3] = 3'd5;
    for (int i = 0; i < 4; i++) beat(i == 3);
    readout(0, 0, 0);
    tick();
    chk("done_pulse", done_a, 0);

    // sign extension
    begin_ctb();
    s51_in = '0; cnt_in = '0;
    cnt_in[0] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      s51_in[0] = (i % 2 == 0) ? 8'hF6 : 8'h03;
      beat(i == 3);
    end
    readout(0, 0, 0);

    // saturation in both widths
    begin_ctb();
    for (int i = 0; i < 1080; i++) begin
      s51_in = '0;
      for (int k = 0; k < N; k++) cnt_in[k] = 3'd5;
      s51_in[1] = (i < 20) ? 8'd15 : 8'd0;
      s51_in[2] = (i >= 20 && i < 40) ? 8'hF0 : 8'h00;
      s51_in[4] = 8'd127;
      s51_in[5] = 8'h80;
      beat(i == 1079);
    end
    readout(0, 0, 0);

    // back-pressure stall
    begin_ctb();
    for (int i = 0; i < 6; i++) begin
      rand_vec();
      beat(i == 5);
    end
    readout(1, 2, 5);

    // reset mid-ACCUM
    begin_ctb();
    for (int i = 0; i < 3; i++) begin
      rand_vec();
      beat(1'b0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("mid_rst");
    begin_ctb();
    s51_in = '0; cnt_in = '0;
    s51_in[0] = 8'd1; cnt_in[0] = 3'd1;
    beat(1'b1);
    readout(0, 0, 0);

    // in_valid in IDLE is ignored
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_vec();
      beat(1'b1);
      chk("idle_inv_busy", busy_a, 0);
      chk("idle_inv_ov", ov_a, 0);
    end

    // start during ACCUM and OUT, start in done cycle
    begin_ctb();
    rand_vec();
    beat(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accum_start_busy", busy_a, 1);
    rand_vec();
    beat(1'b0);
    rand_vec();
    beat(1'b1);
    start = 1'b1;
    readout(2, 0, 0);
    tick();
    start = 1'b0;
    model_clear();
    chk("done_start_busy", busy_a, 1);
    chk("done_start_ov", ov_a, 0);
    rand_vec();
    beat(1'b1);
    readout(0, 0, 0);

    // randomized CTBs with gaps and stray controls
    for (int t = 0; t < 6; t++) begin
      int nb;
      nb = $urandom_range(1, 70);
      begin_ctb();
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_last = 1'($urandom);
          start = 1'($urandom);
          rand_vec();
          tick();
          in_last = 1'b0;
          start = 1'b0;
        end
        rand_vec();
        beat(i == nb - 1);
      end
      readout(2, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
